opb_register_ppc2simulink: RTL and testbench

OPB_REGISTER_PPC2SIMULINK -- requirements
Module: opb_register_ppc2simulink

---
 rtl/opb_register_ppc2simulink_pkg.sv | 30 +++
 rtl/opb_be_merge.sv | 35 +++
 rtl/opb_register_ppc2simulink.sv | 187 ++++++++++++++++++
 tb/tb_opb_register_ppc2simulink.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/opb_register_ppc2simulink_pkg.sv
// ---------------------------------------------------------------------------
// opb_register_ppc2simulink_pkg
//
// Shared definitions for the PPC-to-Simulink OPB register slave:
//   - word offsets of the two decoded registers inside the slave window
//   - transfer FSM state encoding (IDLE / ACK)
//   - width of the effective-write counter
// ---------------------------------------------------------------------------
package opb_register_ppc2simulink_pkg;

   // Word offsets relative to C_BASEADDR (the two low address bits are ignored)
   localparam logic [31:0] REG_OFS = 32'h0000_0000;  // data register, read/write
   localparam logic [31:0] CNT_OFS = 32'h0000_0004;  // write counter, read-only

   // Transfer FSM encoding
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_ACK  = 1'b1;

   // Effective-write counter width
   localparam int CNT_W = 16;

   typedef logic [CNT_W-1:0] wcount_t;

   // Strips the byte-lane bits from a window offset so that any byte address
   // inside a word decodes to that word.
   function automatic logic [31:0] word_of(input logic [31:0] ofs);
      return {ofs[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/opb_be_merge.sv
// ---------------------------------------------------------------------------
// opb_be_merge
//
// Combinational byte-enable merge of a stored word with new write data.
// Byte lane b of the OPB bus (be_i[b], OPB data bits [8b:8b+7]) is the
// b-th most significant byte of the little-endian-numbered vectors here,
// so be_i[0] selects bits [8*NBYTES-1 -: 8].
//
// Ports
//   old_i    [8*NBYTES-1:0]  current register contents
//   new_i    [8*NBYTES-1:0]  write data, already in [MSB:0] order
//   be_i     [0:NBYTES-1]    OPB byte enables, lane 0 first
//   merged_o [8*NBYTES-1:0]  old_i with enabled lanes replaced by new_i
// ---------------------------------------------------------------------------
module opb_be_merge
   import opb_register_ppc2simulink_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic [8*NBYTES-1:0] old_i,
   input  logic [8*NBYTES-1:0] new_i,
   input  logic [0:NBYTES-1]   be_i,
   output logic [8*NBYTES-1:0] merged_o
);

   always_comb begin
      merged_o = old_i;
      for (int b = 0; b < NBYTES; b++) begin
         if (be_i[b]) begin
            merged_o[8*(NBYTES-1-b) +: 8] = new_i[8*(NBYTES-1-b) +: 8];
         end
      end
   end

endmodule

// File: rtl/opb_register_ppc2simulink.sv
// ---------------------------------------------------------------------------
// opb_register_ppc2simulink
//
// OPB slave exposing one software-writable register to user logic.
// Every hit is acknowledged for exactly one cycle, one cycle after it is
// sampled; back-to-back transfers therefore take two cycles each.
//
// Valid/ready semantics: a transfer is offered while OPB_select is high with
// an in-window address; the slave accepts it on the first rising edge where
// it is IDLE, and Sl_xferAck is high for exactly the following cycle. Inputs
// seen during the ACK cycle are ignored, and dropping select during ACK does
// not cancel the acknowledge.
//
// Window map (offset from C_BASEADDR, low two address bits ignored)
//   0x0   data register, byte-enable writes, read back
//   0x4   {16'h0, user_write_count}, writes acked and dropped
//   else  reads 0, writes acked and dropped
//
// Ports
//   OPB_Clk, OPB_Rst           clock, synchronous active-high reset
//   OPB_ABus/BE/DBus/RNW       OPB master request (big-endian bit order)
//   OPB_select, OPB_seqAddr    transfer strobe, burst hint (unused)
//   Sl_DBus, Sl_xferAck        read data (zero outside ACK) and acknowledge
//   Sl_errAck/retry/toutSup    tied low
//   user_data_out              register contents, user bit 31 = OPB bit 0
//   user_data_valid            one-cycle pulse in the ACK of an effective write
//   user_write_count           number of effective writes, wraps at 16 bits
//   dbg_state_o                transfer FSM state (ST_IDLE / ST_ACK)
// ---------------------------------------------------------------------------
module opb_register_ppc2simulink
   import opb_register_ppc2simulink_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR    = 32'h0102_4200,
   parameter logic [31:0] C_HIGHADDR    = 32'h0102_42FF,
   parameter int          C_OPB_AWIDTH  = 32,
   parameter int          C_OPB_DWIDTH  = 32,
   parameter              C_FAMILY      = "virtex6",
   parameter logic [31:0] C_RESET_VALUE = 32'h0000_0000
) (
   input  logic                        OPB_Clk,
   input  logic                        OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
   input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
   input  logic                        OPB_RNW,
   input  logic                        OPB_select,
   input  logic                        OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
   output logic                        Sl_xferAck,
   output logic                        Sl_errAck,
   output logic                        Sl_retry,
   output logic                        Sl_toutSup,
   output logic [C_OPB_DWIDTH-1:0]     user_data_out,
   output logic                        user_data_valid,
   output logic [CNT_W-1:0]            user_write_count,
   output logic [0:0]                  dbg_state_o
);

   localparam int AW = C_OPB_AWIDTH;
   localparam int DW = C_OPB_DWIDTH;
   localparam int NB = DW / 8;

   localparam logic [AW-1:0] BASE = C_BASEADDR[AW-1:0];
   localparam logic [AW-1:0] HIGH = C_HIGHADDR[AW-1:0];

   // The family string only documents the intended target.
   localparam int unused_family_bits = $bits(C_FAMILY);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [0:0]       state_q, state_d;
   logic [DW-1:0]    data_q, data_d;
   logic [DW-1:0]    rdata_q, rdata_d;
   logic             valid_q, valid_d;
   wcount_t          wcnt_q, wcnt_d;

   // ------------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------------
   logic             hit;
   logic             start;
   logic [AW-1:0]    ofs;
   logic [31:0]      ofs_word;
   logic             is_reg;
   logic             is_cnt;
   logic             wr_eff;
   logic [DW-1:0]    wdata;
   logic [DW-1:0]    merged;

   assign hit   = OPB_select && (OPB_ABus >= BASE) && (OPB_ABus <= HIGH);
   // Requests are only sampled in IDLE; the ACK cycle ignores the bus.
   assign start = hit && (state_q == ST_IDLE);

   assign ofs      = OPB_ABus - BASE;
   assign ofs_word = word_of(32'(ofs));
   assign is_reg   = (ofs_word == REG_OFS);
   assign is_cnt   = (ofs_word == CNT_OFS);

   // A write only counts as effective when it targets the data register and
   // enables at least one byte lane.
   assign wr_eff = start && !OPB_RNW && is_reg && (|OPB_BE);

   // OPB bit 0 is the MSB; a whole-vector assignment keeps that ordering.
   assign wdata = OPB_DBus;

   opb_be_merge #(
      .NBYTES (NB)
   ) u_be_merge (
      .old_i    (data_q),
      .new_i    (wdata),
      .be_i     (OPB_BE),
      .merged_o (merged)
   );

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (hit) state_d = ST_ACK;
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      data_d  = data_q;
      wcnt_d  = wcnt_q;
      valid_d = wr_eff;
      if (wr_eff) begin
         data_d = merged;
         wcnt_d = wcnt_q + wcount_t'(1);
      end
   end

   // Read data is captured at the end of the hit cycle and is zero otherwise,
   // so the registered bus output is already zero outside the ACK cycle.
   always_comb begin
      rdata_d = '0;
      if (start && OPB_RNW) begin
         if (is_reg) begin
            rdata_d = data_q;
         end else if (is_cnt) begin
            rdata_d[CNT_W-1:0] = wcnt_q;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         state_q <= ST_IDLE;
         data_q  <= C_RESET_VALUE[DW-1:0];
         rdata_q <= '0;
         valid_q <= 1'b0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         rdata_q <= rdata_d;
         valid_q <= valid_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign Sl_xferAck       = (state_q == ST_ACK);
   assign Sl_DBus          = rdata_q;
   assign Sl_errAck        = 1'b0;
   assign Sl_retry         = 1'b0;
   assign Sl_toutSup       = 1'b0;
   assign user_data_out    = data_q;
   assign user_data_valid  = valid_q;
   assign user_write_count = wcnt_q;
   assign dbg_state_o      = state_q;

   // The burst hint and the byte-lane address bits carry no meaning here.
   logic unused_ok;
   assign unused_ok = &{1'b0, OPB_seqAddr, ofs[1:0]};

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// ---------------------------------------------------------------------------
// tb_opb_register_ppc2simulink
//
// Directed scenarios with literal expectations, then randomized bus traffic.
// A transfer-level model predicts every output for every cycle.
// ---------------------------------------------------------------------------
module tb_opb_register_ppc2simulink;

   localparam logic [31:0] BASE    = 32'h0102_4200;
   localparam logic [31:0] HIGH    = 32'h0102_42FF;
   localparam logic [31:0] RESET_V = 32'h0000_0000;

   // ------------------------------------------------------------------------
   // Clock / reset and DUT
   // ------------------------------------------------------------------------
   logic        clk = 1'b0;
   logic        rst;
   logic [0:31] abus;
   logic [0:3]  be;
   logic [0:31] dbus;
   logic        rnw;
   logic        sel;
   logic        seq;

   logic [0:31] sl_dbus;
   logic        sl_ack;
   logic        sl_err;
   logic        sl_retry;
   logic        sl_tout;
   logic [31:0] udata;
   logic        uvalid;
   logic [15:0] ucount;
   logic [0:0]  dbg_state;

   always #5 clk = ~clk;

   opb_register_ppc2simulink #(
      .C_BASEADDR    (BASE),
      .C_HIGHADDR    (HIGH),
      .C_OPB_AWIDTH  (32),
      .C_OPB_DWIDTH  (32),
      .C_FAMILY      ("virtex6"),
      .C_RESET_VALUE (RESET_V)
   ) dut (
      .OPB_Clk          (clk),
      .OPB_Rst          (rst),
      .OPB_ABus         (abus),
      .OPB_BE           (be),
      .OPB_DBus         (dbus),
      .OPB_RNW          (rnw),
      .OPB_select       (sel),
      .OPB_seqAddr      (seq),
      .Sl_DBus          (sl_dbus),
      .Sl_xferAck       (sl_ack),
      .Sl_errAck        (sl_err),
      .Sl_retry         (sl_retry),
      .Sl_toutSup       (sl_tout),
      .user_data_out    (udata),
      .user_data_valid  (uvalid),
      .user_write_count (ucount),
      .dbg_state_o      (dbg_state)
   );

   // ------------------------------------------------------------------------
   // Scoreboard bookkeeping
   // ------------------------------------------------------------------------
   int checks   = 0;
   int failures = 0;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endfunction

   // ------------------------------------------------------------------------
   // Transfer-level model: a request is taken whenever the slave is not
   // already acknowledging; the ack, read data and write effects all show up
   // in the cycle after it is taken.
   // ------------------------------------------------------------------------
   logic [31:0] m_reg;
   int          m_cnt;
   logic        m_ack;
   logic [31:0] m_dbus;
   logic        m_valid;
   logic        m_live = 1'b0;

   always @(posedge clk) begin : model
      logic        take;
      logic [31:0] word;
      take = 1'b0;
      word = 32'h0;
      if (rst) begin
         m_ack   = 1'b0;
         m_dbus  = 32'h0;
         m_valid = 1'b0;
         m_reg   = RESET_V;
         m_cnt   = 0;
      end else begin
         take    = sel && (abus >= BASE) && (abus <= HIGH) && !m_ack;
         m_ack   = take;
         m_dbus  = 32'h0;
         m_valid = 1'b0;
         if (take) begin
            word = (abus - BASE) & ~32'h3;
            if (rnw) begin
               if (word == 32'h0)      m_dbus = m_reg;
               else if (word == 32'h4) m_dbus = 32'(m_cnt);
            end else if (word == 32'h0 && be != 4'b0000) begin
               for (int b = 0; b < 4; b++) begin
                  if (be[b]) m_reg[31-8*b -: 8] = dbus[8*b +: 8];
               end
               m_cnt   = (m_cnt + 1) % 65536;
               m_valid = 1'b1;
            end
         end
      end
      m_live = 1'b1;
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_live) begin
         check("xfer_ack",    32'(sl_ack),    32'(m_ack));
         check("sl_dbus",     sl_dbus,        m_dbus);
         check("user_data",   udata,          m_reg);
         check("user_valid",  32'(uvalid),    32'(m_valid));
         check("user_count",  32'(ucount),    32'(m_cnt));
         check("dbg_state",   32'(dbg_state), 32'(m_ack));
         check("tied_low",    {29'h0, sl_err, sl_retry, sl_tout}, 32'h0);
      end
   end

   // ------------------------------------------------------------------------
   // Driver tasks (inputs change on the falling edge only)
   // ------------------------------------------------------------------------
   task automatic bus_idle();
      sel  = 1'b0;
      rnw  = 1'b0;
      be   = 4'b0000;
      abus = 32'h0;
      dbus = 32'h0;
   endtask

   // Offers one transfer for a single cycle and returns at the falling edge
   // of the following (ACK) cycle with select already dropped.
   task automatic xfer(input logic [31:0] a, input logic r, input logic [3:0] b,
                       input logic [31:0] d);
      @(negedge clk);
      sel  = 1'b1;
      abus = a;
      rnw  = r;
      be   = b;
      dbus = d;
      @(negedge clk);
      bus_idle();
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      rst = 1'b1;
      seq = 1'b0;
      bus_idle();
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      check("rst_ack",   32'(sl_ack), 32'h0);
      check("rst_dbus",  sl_dbus,     32'h0);
      check("rst_data",  udata,       RESET_V);
      check("rst_count", 32'(ucount), 32'h0);

      // Full-word write
      xfer(BASE, 1'b0, 4'b1111, 32'hDEAD_BEEF);
      check("wr1_ack",   32'(sl_ack), 32'h1);
      check("wr1_data",  udata,       32'hDEAD_BEEF);
      check("wr1_valid", 32'(uvalid), 32'h1);
      check("wr1_count", 32'(ucount), 32'h1);
      @(negedge clk);
      check("wr1_valid_once", 32'(uvalid), 32'h0);
      check("wr1_ack_once",   32'(sl_ack), 32'h0);

      // Partial write on lanes 1 and 3
      xfer(BASE, 1'b0, 4'b0101, 32'h1122_3344);
      check("wr2_data",  udata,       32'hDE22_BE44);
      check("wr2_count", 32'(ucount), 32'h2);

      // No byte enabled: acked, nothing else happens
      xfer(BASE, 1'b0, 4'b0000, 32'hFFFF_FFFF);
      check("wr0_ack",   32'(sl_ack), 32'h1);
      check("wr0_data",  udata,       32'hDE22_BE44);
      check("wr0_valid", 32'(uvalid), 32'h0);
      check("wr0_count", 32'(ucount), 32'h2);

      // Reads of the data register and the counter
      xfer(BASE, 1'b1, 4'b1111, 32'h0);
      check("rd_reg_ack", 32'(sl_ack), 32'h1);
      check("rd_reg",     sl_dbus,     32'hDE22_BE44);
      xfer(BASE + 32'h4, 1'b1, 4'b1111, 32'h0);
      check("rd_cnt",     sl_dbus,     32'h0000_0002);
      @(negedge clk);
      check("rd_after",   sl_dbus,     32'h0);

      // Outside the window, then the last word of the window
      xfer(32'h0102_4300, 1'b1, 4'b1111, 32'h0);
      check("miss_ack",  32'(sl_ack), 32'h0);
      check("miss_dbus", sl_dbus,     32'h0);
      xfer(32'h0102_42FC, 1'b1, 4'b1111, 32'h0);
      check("edge_ack",  32'(sl_ack), 32'h1);
      check("edge_dbus", sl_dbus,     32'h0);

      // Counter wrap: preload the counter close to the top to keep the run
      // short, then five effective writes carry it through 0xFFFF to 0x0001.
      @(negedge clk);
      dut.wcnt_q = 16'hFFFC;
      m_cnt      = 32'hFFFC;
      for (int i = 0; i < 5; i++) begin
         xfer(BASE, 1'b0, 4'b1000, $urandom);
      end
      check("wrap_count", 32'(ucount), 32'h0000_0001);

      // Reset asserted in a hit cycle wins over the write
      @(negedge clk);
      rst  = 1'b1;
      sel  = 1'b1;
      abus = BASE;
      rnw  = 1'b0;
      be   = 4'b1111;
      dbus = 32'hCAFE_F00D;
      @(negedge clk);
      rst = 1'b0;
      bus_idle();
      check("rsthit_ack",   32'(sl_ack), 32'h0);
      check("rsthit_data",  udata,       RESET_V);
      check("rsthit_count", 32'(ucount), 32'h0);
      check("rsthit_valid", 32'(uvalid), 32'h0);

      // Randomized traffic: arbitrary select patterns, back-to-back hits,
      // select dropping during ACK, misses around both bounds, rare resets.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         sel = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 7))
            0:       abus = BASE;
            1:       abus = BASE + 32'h4;
            2:       abus = BASE + 32'($urandom_range(0, 255));
            3:       abus = HIGH;
            4:       abus = BASE - 32'h1;
            5:       abus = HIGH + 32'h1;
            6:       abus = $urandom;
            default: abus = BASE + 32'($urandom_range(0, 7));
         endcase
         rnw  = ($urandom_range(0, 2) == 0);
         be   = 4'($urandom_range(0, 15));
         dbus = $urandom;
         seq  = 1'($urandom_range(0, 1));
         rst  = ($urandom_range(0, 299) == 0);
      end
      @(negedge clk);
      rst = 1'b0;
      seq = 1'b0;
      bus_idle();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
